// File: rtl/bsg_manycore_mem_pkg.sv
// Shared types for the manycore local-memory port arbiter and its starvation arbiter.
package bsg_manycore_mem_pkg;

  // Request structs are sized for the widest supported port and sliced down by users.
  localparam int unsigned MemMaxDataWidth = 64;
  localparam int unsigned MemMaxMaskWidth = MemMaxDataWidth >> 3;
  localparam int unsigned MemMaxAddrWidth = 16;
  localparam int unsigned StarveCntWidth  = 4;

  // Bit positions inside the one-hot {net, core} grant / read-pending vectors
  localparam int unsigned GntNet  = 1;
  localparam int unsigned GntCore = 0;

  typedef struct packed {
    logic [MemMaxDataWidth-1:0] data;
    logic [MemMaxMaskWidth-1:0] mask;
    logic [MemMaxAddrWidth-1:0] addr;
    logic                       we;
  } mem_req_s;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_NET,
    SRC_CORE
  } req_src_e;

  function automatic req_src_e grant_to_src(input logic [1:0] gnt);
    req_src_e src;
    src = SRC_NONE;
    if (gnt[GntNet]) begin
      src = SRC_NET;
    end else if (gnt[GntCore]) begin
      src = SRC_CORE;
    end
    return src;
  endfunction

endpackage

// File: rtl/bsg_manycore_mem_starve_arb.sv
// Two-input priority arbiter (core over network) with a saturating starvation counter
// that forces a network grant after starve_limit_p consecutive losses.
module bsg_manycore_mem_starve_arb
  import bsg_manycore_mem_pkg::*;
#(
  parameter int unsigned starve_limit_p = 4,
  parameter int unsigned debug_p        = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       net_v_i,
  input  logic       core_v_i,
  output logic [1:0] grant_o,
  output logic       forced_o
);

  localparam logic [StarveCntWidth-1:0] StarveLimit = StarveCntWidth'(starve_limit_p);

  logic [StarveCntWidth-1:0] starve_cnt_q, starve_cnt_d;
  logic                      at_limit;

  assign at_limit = (starve_cnt_q == StarveLimit);

  always_comb begin
    grant_o      = '0;
    forced_o     = 1'b0;
    starve_cnt_d = starve_cnt_q;

    if (!reset_i) begin
      grant_o[GntNet]  = net_v_i & (~core_v_i | at_limit);
      grant_o[GntCore] = core_v_i & ~grant_o[GntNet];
      forced_o         = net_v_i & core_v_i & at_limit;

      // A losing network request can only lose to the core, so this is the "core won" leg.
      if (!net_v_i || grant_o[GntNet]) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < StarveLimit) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  if (debug_p != 0) begin : g_debug
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        assert (starve_cnt_q <= StarveLimit);
        assert (!(grant_o[GntNet] && grant_o[GntCore]));
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_mem_port_arb.sv
// Arbitrates network and core requests onto the single-port local SRAM and steers the
// 1-cycle read data back. Optional BSG_MANYCORE_MEM_PORT_STATS_EN adds grant counters.
module bsg_manycore_mem_port_arb
  import bsg_manycore_mem_pkg::*;
#(
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned addr_width_p   = 10,
  parameter int unsigned starve_limit_p = 4,
  parameter int unsigned debug_p        = 0,
  localparam int unsigned mask_width_lp = data_width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     net_v_i,
  output logic                     net_yumi_o,
  input  logic [data_width_p-1:0]  net_data_i,
  input  logic [mask_width_lp-1:0] net_mask_i,
  input  logic [addr_width_p-1:0]  net_addr_i,
  input  logic                     net_we_i,
  output logic                     net_returning_v_o,
  output logic [data_width_p-1:0]  net_returning_data_o,

  input  logic                     core_v_i,
  output logic                     core_yumi_o,
  input  logic [data_width_p-1:0]  core_data_i,
  input  logic [mask_width_lp-1:0] core_mask_i,
  input  logic [addr_width_p-1:0]  core_addr_i,
  input  logic                     core_we_i,
  output logic                     core_returning_v_o,
  output logic [data_width_p-1:0]  core_returning_data_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_p-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]  mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]  mem_data_i
`ifdef BSG_MANYCORE_MEM_PORT_STATS_EN
  ,
  output logic [31:0]              stat_net_cnt_o,
  output logic [31:0]              stat_starve_cnt_o
`endif
);

  logic [1:0] gnt;
  logic       arb_forced;
  req_src_e   src;
  mem_req_s   net_req, core_req, sel_req;
  logic [1:0] rd_pending_q, rd_pending_d;

  bsg_manycore_mem_starve_arb #(
    .starve_limit_p(starve_limit_p),
    .debug_p       (debug_p)
  ) u_starve_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .net_v_i (net_v_i),
    .core_v_i(core_v_i),
    .grant_o (gnt),
    .forced_o(arb_forced)
  );

  assign net_yumi_o  = gnt[GntNet];
  assign core_yumi_o = gnt[GntCore];
  assign src         = grant_to_src(gnt);

  always_comb begin
    net_req                         = '0;
    net_req.data[data_width_p-1:0]  = net_data_i;
    net_req.mask[mask_width_lp-1:0] = net_mask_i;
    net_req.addr[addr_width_p-1:0]  = net_addr_i;
    net_req.we                      = net_we_i;

    core_req                         = '0;
    core_req.data[data_width_p-1:0]  = core_data_i;
    core_req.mask[mask_width_lp-1:0] = core_mask_i;
    core_req.addr[addr_width_p-1:0]  = core_addr_i;
    core_req.we                      = core_we_i;
  end

  // Ungranted cycles drive an all-zero request so the SRAM pins stay quiet.
  always_comb begin
    sel_req = '0;
    unique case (src)
      SRC_NET:  sel_req = net_req;
      SRC_CORE: sel_req = core_req;
      default:  sel_req = '0;
    endcase
  end

  assign mem_v_o    = |gnt;
  assign mem_w_o    = sel_req.we;
  assign mem_addr_o = sel_req.addr[addr_width_p-1:0];
  assign mem_data_o = sel_req.data[data_width_p-1:0];
  assign mem_mask_o = sel_req.mask[mask_width_lp-1:0];

  // Padding bits above the configured widths are never routed anywhere.
  logic unused_sel_req;
  assign unused_sel_req = ^sel_req;

  always_comb begin
    rd_pending_d          = '0;
    rd_pending_d[GntNet]  = gnt[GntNet] & ~net_we_i;
    rd_pending_d[GntCore] = gnt[GntCore] & ~core_we_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pending_q <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  // Gating with reset_i kills the return of a read granted just before reset.
  assign net_returning_v_o     = rd_pending_q[GntNet] & ~reset_i;
  assign core_returning_v_o    = rd_pending_q[GntCore] & ~reset_i;
  assign net_returning_data_o  = mem_data_i;
  assign core_returning_data_o = mem_data_i;

`ifdef BSG_MANYCORE_MEM_PORT_STATS_EN
  logic [31:0] stat_net_cnt_q, stat_starve_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_net_cnt_q    <= '0;
      stat_starve_cnt_q <= '0;
    end else begin
      if (gnt[GntNet]) begin
        stat_net_cnt_q <= stat_net_cnt_q + 32'd1;
      end
      if (arb_forced) begin
        stat_starve_cnt_q <= stat_starve_cnt_q + 32'd1;
      end
    end
  end

  assign stat_net_cnt_o    = stat_net_cnt_q;
  assign stat_starve_cnt_o = stat_starve_cnt_q;
`else
  logic unused_forced;
  assign unused_forced = arb_forced;
`endif

endmodule
